// File: rtl/toll_pkg.sv
// Shared vehicle class codes, lane state encoding and default timing for the
// toll lane sequencer.
package toll_pkg;

  typedef enum logic [1:0] {
    VEH_BIKE  = 2'b00,
    VEH_CAR   = 2'b01,
    VEH_BUS   = 2'b10,
    VEH_TRUCK = 2'b11
  } vehicle_class_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TAG,
    CHARGE,
    OPEN,
    REJECT
  } lane_state_t;

  localparam int DEF_TAG_TIMEOUT  = 16;
  localparam int DEF_GATE_HOLD    = 8;
  localparam int DEF_ALARM_CYCLES = 4;
  localparam int DEF_REV_W        = 16;
  localparam int DEF_CNT_W        = 8;
  localparam int TIMER_W          = 8;

endpackage

// File: rtl/lane_timer.sv
// Loadable down-counter shared by the tag timeout, gate hold and alarm windows.
// The count parks at zero, so done stays asserted until the next load.
module lane_timer
  import toll_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/toll_lane_controller.sv
// Per-lane sequencer: detects a vehicle, collects its tag, drives the external
// fee calculator for one cycle, then operates gate/alarm and keeps statistics.
module toll_lane_controller
  import toll_pkg::*;
#(
  parameter int TAG_TIMEOUT  = DEF_TAG_TIMEOUT,
  parameter int GATE_HOLD    = DEF_GATE_HOLD,
  parameter int ALARM_CYCLES = DEF_ALARM_CYCLES,
  parameter int REV_W        = DEF_REV_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vehicle_detect,
  input  logic             tag_valid,
  input  logic [1:0]       tag_vehicle_type,
  input  logic [7:0]       tag_balance,
  output logic             calc_enable,
  output logic [1:0]       calc_vehicle_type,
  output logic [7:0]       calc_balance,
  input  logic [7:0]       calc_toll_fee,
  input  logic [7:0]       calc_updated_balance,
  input  logic             calc_reject,
  output logic             wb_valid,
  output logic [7:0]       wb_balance,
  output logic             gate_open,
  output logic             alarm,
  output logic             busy,
  output logic [REV_W-1:0] revenue,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] reject_count
);

  // Timer loads are "cycles remaining after this one", so a window of N cycles loads N-1.
  localparam logic [TIMER_W-1:0] TAG_LOAD   = TIMER_W'(TAG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(GATE_HOLD - 1);
  localparam logic [TIMER_W-1:0] ALARM_LOAD = TIMER_W'(ALARM_CYCLES - 1);

  lane_state_t        state;
  lane_state_t        next_state;
  logic               prev_detect;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;
  logic [REV_W:0]     rev_sum;

  lane_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  assign rev_sum = {1'b0, revenue} + (REV_W+1)'(calc_toll_fee);

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (vehicle_detect && !prev_detect) begin
          next_state  = WAIT_TAG;
          timer_load  = 1'b1;
          timer_value = TAG_LOAD;
        end
      end
      WAIT_TAG: begin
        // A departing vehicle beats a tag; a tag on the last window cycle beats the timeout.
        if (!vehicle_detect) begin
          next_state = IDLE;
        end else if (tag_valid) begin
          next_state = CHARGE;
        end else if (timer_done) begin
          next_state  = REJECT;
          timer_load  = 1'b1;
          timer_value = ALARM_LOAD;
        end
      end
      CHARGE: begin
        timer_load = 1'b1;
        if (calc_reject) begin
          next_state  = REJECT;
          timer_value = ALARM_LOAD;
        end else begin
          next_state  = OPEN;
          timer_value = HOLD_LOAD;
        end
      end
      OPEN, REJECT: begin
        if (timer_done && !vehicle_detect) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      prev_detect       <= 1'b0;
      calc_enable       <= 1'b0;
      calc_vehicle_type <= '0;
      calc_balance      <= '0;
      wb_valid          <= 1'b0;
      wb_balance        <= '0;
      gate_open         <= 1'b0;
      alarm             <= 1'b0;
      busy              <= 1'b0;
      revenue           <= '0;
      pass_count        <= '0;
      reject_count      <= '0;
    end else begin
      state       <= next_state;
      prev_detect <= vehicle_detect;
      calc_enable <= (next_state == CHARGE);
      gate_open   <= (next_state == OPEN);
      busy        <= (next_state != IDLE);
      alarm       <= (next_state == REJECT) && ((state != REJECT) || !timer_done);
      wb_valid    <= (state == CHARGE) && !calc_reject;

      if (state == WAIT_TAG && next_state == CHARGE) begin
        calc_vehicle_type <= tag_vehicle_type;
        calc_balance      <= tag_balance;
      end

      if (state == CHARGE && !calc_reject) begin
        wb_balance <= calc_updated_balance;
        revenue    <= rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
        pass_count <= pass_count + CNT_W'(1);
      end

      if ((state == CHARGE && calc_reject) || (state == WAIT_TAG && next_state == REJECT)) begin
        reject_count <= reject_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_toll_lane_controller.sv
// Directed bench for toll_lane_controller: a timeline model predicts every
// output per cycle; literal checks pin latency, hold lengths and totals.
module tb_toll_lane_controller;
  import toll_pkg::*;

  localparam int TB_REV_W = 8;
  localparam int TB_CNT_W = 8;
  localparam int TOUT     = 16;
  localparam int HOLD     = 8;
  localparam int ALRM     = 4;
  localparam int MAXC     = 2048;

  logic                clk = 1'b0;
  logic                reset;
  logic                vehicle_detect;
  logic                tag_valid;
  logic [1:0]          tag_vehicle_type;
  logic [7:0]          tag_balance;
  logic                calc_enable;
  logic [1:0]          calc_vehicle_type;
  logic [7:0]          calc_balance;
  logic [7:0]          calc_toll_fee;
  logic [7:0]          calc_updated_balance;
  logic                calc_reject;
  logic                wb_valid;
  logic [7:0]          wb_balance;
  logic                gate_open;
  logic                alarm;
  logic                busy;
  logic [TB_REV_W-1:0] revenue;
  logic [TB_CNT_W-1:0] pass_count;
  logic [TB_CNT_W-1:0] reject_count;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  toll_lane_controller #(
    .TAG_TIMEOUT (TOUT),
    .GATE_HOLD   (HOLD),
    .ALARM_CYCLES(ALRM),
    .REV_W       (TB_REV_W),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .vehicle_detect      (vehicle_detect),
    .tag_valid           (tag_valid),
    .tag_vehicle_type    (tag_vehicle_type),
    .tag_balance         (tag_balance),
    .calc_enable         (calc_enable),
    .calc_vehicle_type   (calc_vehicle_type),
    .calc_balance        (calc_balance),
    .calc_toll_fee       (calc_toll_fee),
    .calc_updated_balance(calc_updated_balance),
    .calc_reject         (calc_reject),
    .wb_valid            (wb_valid),
    .wb_balance          (wb_balance),
    .gate_open           (gate_open),
    .alarm               (alarm),
    .busy                (busy),
    .revenue             (revenue),
    .pass_count          (pass_count),
    .reject_count        (reject_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fee_of(input logic [1:0] cls);
    case (cls)
      VEH_BIKE: fee_of = 8'd5;
      VEH_CAR:  fee_of = 8'd10;
      VEH_BUS:  fee_of = 8'd15;
      default:  fee_of = 8'd20;
    endcase
  endfunction

  // Stand-in for the external fee calculator.
  always_comb begin
    calc_toll_fee        = fee_of(calc_vehicle_type);
    calc_reject          = (calc_balance < calc_toll_fee);
    calc_updated_balance = calc_reject ? calc_balance : calc_balance - calc_toll_fee;
  end

  // Per-cycle expectations: pulses/levels, plus sticky-value update events.
  bit       gate_exp  [MAXC];
  bit       alarm_exp [MAXC];
  bit       busy_exp  [MAXC];
  bit       cen_exp   [MAXC];
  bit       wbv_exp   [MAXC];
  bit       latch_v   [MAXC];
  bit [1:0] latch_cls [MAXC];
  bit [7:0] latch_bal [MAXC];
  bit       wbb_v     [MAXC];
  bit [7:0] wbb_val   [MAXC];
  bit       rev_v     [MAXC];
  bit [7:0] rev_fee   [MAXC];
  bit       pass_inc  [MAXC];
  bit       rej_inc   [MAXC];

  int m_cls, m_bal, m_wbb, m_rev, m_pass, m_rej;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic clear_from(input int from);
    for (int c = from; c < MAXC; c++) begin
      gate_exp[c] = 0; alarm_exp[c] = 0; busy_exp[c] = 0; cen_exp[c] = 0; wbv_exp[c] = 0;
      latch_v[c] = 0; wbb_v[c] = 0; rev_v[c] = 0; pass_inc[c] = 0; rej_inc[c] = 0;
    end
  endtask

  task automatic set_range(inout bit arr [MAXC], input int lo, input int hi);
    for (int c = lo; c <= hi && c < MAXC; c++) arr[c] = 1;
  endtask

  // Timeline of one vehicle: rising detect at d, tag at t, detect low from l.
  task automatic model_vehicle(input int d, input int t, input int l, input bit has_tag,
                               input logic [1:0] cls, input logic [7:0] bal, output int last);
    int fee;
    if (has_tag && l > t) begin
      fee = fee_of(cls);
      cen_exp[t+1] = 1;
      latch_v[t+1] = 1; latch_cls[t+1] = cls; latch_bal[t+1] = bal;
      if (bal >= fee) begin
        last = (t + 1 + HOLD > l) ? t + 1 + HOLD : l;
        set_range(gate_exp, t + 2, last);
        wbv_exp[t+2] = 1;
        wbb_v[t+2] = 1; wbb_val[t+2] = bal - 8'(fee);
        rev_v[t+2] = 1; rev_fee[t+2] = 8'(fee);
        pass_inc[t+2] = 1;
      end else begin
        last = (t + 1 + ALRM > l) ? t + 1 + ALRM : l;
        set_range(alarm_exp, t + 2, t + 1 + ALRM);
        rej_inc[t+2] = 1;
      end
    end else if (l <= d + TOUT) begin
      last = l;
    end else begin
      last = (d + TOUT + ALRM > l) ? d + TOUT + ALRM : l;
      set_range(alarm_exp, d + TOUT + 1, d + TOUT + ALRM);
      rej_inc[d+TOUT+1] = 1;
    end
    set_range(busy_exp, d + 1, last);
  endtask

  // Compare process: applies the model's events for the cycle, then checks all outputs.
  initial begin : compare
    bit rst_s;
    forever begin
      @(posedge clk);
      rst_s = reset;
      @(negedge clk);
      if (rst_s) begin
        m_cls = 0; m_bal = 0; m_wbb = 0; m_rev = 0; m_pass = 0; m_rej = 0;
      end
      if (latch_v[cyc]) begin m_cls = latch_cls[cyc]; m_bal = latch_bal[cyc]; end
      if (wbb_v[cyc]) m_wbb = wbb_val[cyc];
      if (rev_v[cyc]) m_rev = (m_rev + rev_fee[cyc] > (1 << TB_REV_W) - 1) ? (1 << TB_REV_W) - 1
                                                                            : m_rev + rev_fee[cyc];
      if (pass_inc[cyc]) m_pass = (m_pass + 1) % (1 << TB_CNT_W);
      if (rej_inc[cyc]) m_rej = (m_rej + 1) % (1 << TB_CNT_W);
      checkOutput("gate_open", 32'(gate_open), 32'(gate_exp[cyc]));
      checkOutput("alarm", 32'(alarm), 32'(alarm_exp[cyc]));
      checkOutput("busy", 32'(busy), 32'(busy_exp[cyc]));
      checkOutput("calc_enable", 32'(calc_enable), 32'(cen_exp[cyc]));
      checkOutput("wb_valid", 32'(wb_valid), 32'(wbv_exp[cyc]));
      checkOutput("wb_balance", 32'(wb_balance), 32'(m_wbb));
      checkOutput("calc_vehicle_type", 32'(calc_vehicle_type), 32'(m_cls));
      checkOutput("calc_balance", 32'(calc_balance), 32'(m_bal));
      checkOutput("revenue", 32'(revenue), 32'(m_rev));
      checkOutput("pass_count", 32'(pass_count), 32'(m_pass));
      checkOutput("reject_count", 32'(reject_count), 32'(m_rej));
    end
  end

  // Independent run-length and timestamp observers for the literal checks.
  int gate_run = 0, gate_last_run = 0, alarm_run = 0, alarm_last_run = 0, wb_cyc = -1;
  always @(negedge clk) begin
    if (gate_open === 1'b1) gate_run <= gate_run + 1;
    else if (gate_run != 0) begin gate_last_run <= gate_run; gate_run <= 0; end
    if (alarm === 1'b1) alarm_run <= alarm_run + 1;
    else if (alarm_run != 0) begin alarm_last_run <= alarm_run; alarm_run <= 0; end
    if (wb_valid === 1'b1) wb_cyc <= cyc;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] cls, input logic [7:0] bal, input bit has_tag,
                               input int tag_delay, input int leave_delay, output int t_out);
    int d, t, l, last;
    d = cyc;
    t = d + tag_delay;
    l = d + leave_delay;
    t_out = t;
    model_vehicle(d, t, l, has_tag, cls, bal, last);
    tag_vehicle_type = cls;
    tag_balance      = bal;
    for (int c = d; c <= last; c++) begin
      vehicle_detect = (c < l);
      tag_valid      = has_tag && (c == t);
      next_cycle();
    end
    vehicle_detect   = 1'b0;
    tag_vehicle_type = 2'b10;
    tag_balance      = 8'hEE;
    tag_valid        = 1'b1;
    next_cycle();
    tag_valid = 1'b0;
    next_cycle();
  endtask

  task automatic applyResetInOpen();
    int d, t, last;
    d = cyc;
    t = d + 1;
    model_vehicle(d, t, d + 40, 1'b1, VEH_CAR, 8'd50, last);
    tag_vehicle_type = VEH_CAR;
    tag_balance      = 8'd50;
    for (int c = d; c < t + 4; c++) begin
      vehicle_detect = 1'b1;
      tag_valid      = (c == t);
      next_cycle();
    end
    reset          = 1'b1;
    vehicle_detect = 1'b0;
    tag_valid      = 1'b0;
    clear_from(cyc + 1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_gate_open", 32'(gate_open), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_revenue", 32'(revenue), 32'd0);
    checkOutput("reset_pass_count", 32'(pass_count), 32'd0);
    checkOutput("reset_wb_balance", 32'(wb_balance), 32'd0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    int t;
    clear_from(0);
    reset            = 1'b1;
    vehicle_detect   = 1'b0;
    tag_valid        = 1'b0;
    tag_vehicle_type = '0;
    tag_balance      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    next_cycle();

    $display("[TB] car, balance 50");
    applyStimulus(VEH_CAR, 8'd50, 1'b1, 2, 20, t);
    checkOutput("car_wb_latency", 32'(wb_cyc - t), 32'd2);
    checkOutput("car_wb_balance", 32'(wb_balance), 32'd40);
    checkOutput("car_revenue", 32'(revenue), 32'd10);
    checkOutput("car_pass_count", 32'(pass_count), 32'd1);

    $display("[TB] truck, balance 15, rejected");
    applyStimulus(VEH_TRUCK, 8'd15, 1'b1, 3, 4, t);
    checkOutput("truck_alarm_len", 32'(alarm_last_run), 32'd4);
    checkOutput("truck_reject_count", 32'(reject_count), 32'd1);
    checkOutput("truck_wb_unchanged", 32'(wb_balance), 32'd40);

    $display("[TB] tag timeout");
    applyStimulus(VEH_CAR, 8'd99, 1'b0, 1, 22, t);
    checkOutput("timeout_reject_count", 32'(reject_count), 32'd2);
    checkOutput("timeout_busy", 32'(busy), 32'd0);

    $display("[TB] back-out beats same-cycle tag");
    applyStimulus(VEH_BUS, 8'd80, 1'b1, 5, 5, t);
    checkOutput("backout_pass_count", 32'(pass_count), 32'd1);
    checkOutput("backout_reject_count", 32'(reject_count), 32'd2);

    $display("[TB] tag on final timeout cycle");
    applyStimulus(VEH_CAR, 8'd30, 1'b1, TOUT, 30, t);
    checkOutput("late_tag_revenue", 32'(revenue), 32'd20);
    checkOutput("late_tag_pass_count", 32'(pass_count), 32'd2);

    $display("[TB] gate hold after early departure");
    applyStimulus(VEH_BIKE, 8'd9, 1'b1, 1, 5, t);
    checkOutput("hold_gate_len", 32'(gate_last_run), 32'd8);
    checkOutput("hold_wb_balance", 32'(wb_balance), 32'd4);
    checkOutput("hold_revenue", 32'(revenue), 32'd25);

    $display("[TB] reset while gate open");
    applyResetInOpen();
    checkOutput("post_reset_reject_count", 32'(reject_count), 32'd0);

    $display("[TB] revenue saturation with trucks");
    for (int i = 0; i < 12; i++) applyStimulus(VEH_TRUCK, 8'd200, 1'b1, 2, 3, t);
    checkOutput("trucks12_revenue", 32'(revenue), 32'd240);
    applyStimulus(VEH_TRUCK, 8'd200, 1'b1, 2, 3, t);
    checkOutput("trucks13_revenue", 32'(revenue), 32'd255);
    checkOutput("trucks13_pass_count", 32'(pass_count), 32'd13);
    checkOutput("trucks13_wb_balance", 32'(wb_balance), 32'd180);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
